// File: rtl/if_stage_if.sv
// Fetch-stage bus: stall/redirect inputs, ROM address/data, instruction hand-off to ID.
// Pure wiring; no latency of its own.
// Backpressure travels on iStall; the master side freezes while it is high.
interface if_stage_if #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 16
);
    logic               iStall;
    logic               iBranchTaken;
    logic [ADDR_W-1:0]  iBranchDir;
    logic [ADDR_W-1:0]  oInstrAddr;
    logic [INSTR_W-1:0] iInstrData;
    logic [INSTR_W-1:0] oInstr;
    logic [ADDR_W-1:0]  oNewPC;
    logic               oValid;

    // Fetch stage side
    modport master (
        input  iStall, iBranchTaken, iBranchDir, iInstrData,
        output oInstrAddr, oInstr, oNewPC, oValid
    );

    // Environment side: pipeline control, ROM and ID stage
    modport slave (
        output iStall, iBranchTaken, iBranchDir, iInstrData,
        input  oInstrAddr, oInstr, oNewPC, oValid
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, drives a sync-read ROM, hands instruction + PC+1 to ID.
// Latency: 2 cycles from address issue to oInstr; a redirect costs 2 bubble cycles.
// Backpressure: iStall freezes PC and outputs and re-issues the in-flight address to the ROM.
module if_stage #(
    parameter int              ADDR_W    = 10,
    parameter int              INSTR_W   = 16,
    parameter logic [15:0]     NOP_INSTR = 16'h0000
) (
    input  logic      Clock,
    input  logic      Reset,
    if_stage_if.master bus
);

    typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

    localparam logic [ADDR_W-1:0]  ADDR_ONE = ADDR_W'(1);
    localparam logic [INSTR_W-1:0] NOP_W    = INSTR_W'(NOP_INSTR);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  fetch_addr_q, fetch_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  new_pc_q, new_pc_d;
    logic               valid_q, valid_d;

    // Under a RUN stall re-issue fetchAddr so the ROM keeps returning the word it belongs to
    always_comb begin
        bus.oInstrAddr = (state_q == RUN && bus.iStall) ? fetch_addr_q : pc_q;
    end

    // Next-state: branch beats stall beats normal advance
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        instr_d      = instr_q;
        new_pc_d     = new_pc_q;
        valid_d      = valid_q;

        if (bus.iBranchTaken) begin
            // Word in flight is dropped; oNewPC intentionally keeps its last value
            pc_d    = bus.iBranchDir;
            state_d = FILL;
            instr_d = NOP_W;
            valid_d = 1'b0;
        end else if (!bus.iStall) begin
            unique case (state_q)
                FILL: begin
                    fetch_addr_d = pc_q;
                    pc_d         = pc_q + ADDR_ONE;
                    state_d      = RUN;
                    instr_d      = NOP_W;
                    valid_d      = 1'b0;
                end
                RUN: begin
                    instr_d      = bus.iInstrData;
                    new_pc_d     = fetch_addr_q + ADDR_ONE;
                    valid_d      = 1'b1;
                    fetch_addr_d = pc_q;
                    pc_d         = pc_q + ADDR_ONE;
                end
                default: ;
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= FILL;
            pc_q         <= '0;
            fetch_addr_q <= '0;
            instr_q      <= NOP_W;
            new_pc_q     <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            instr_q      <= instr_d;
            new_pc_q     <= new_pc_d;
            valid_q      <= valid_d;
        end
    end

    assign bus.oInstr = instr_q;
    assign bus.oNewPC = new_pc_q;
    assign bus.oValid = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a ROM returning word(k) = 16'hA000 + k.
// Inputs change and outputs are sampled on the falling edge; cycle numbers count from reset release.
// Each scenario task carries its own inline comparisons.
module tb_if_stage;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    if_stage_if #(.ADDR_W(10), .INSTR_W(16)) bus ();

    if_stage #(.ADDR_W(10), .INSTR_W(16), .NOP_INSTR(16'h0000)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    // Synchronous-read instruction ROM
    always @(posedge Clock) bus.iInstrData <= 16'hA000 + {6'd0, bus.oInstrAddr};

    task automatic tick();
        @(negedge Clock);
        cyc++;
    endtask

    task automatic start();
        Reset            = 1'b1;
        bus.iStall       = 1'b0;
        bus.iBranchTaken = 1'b0;
        bus.iBranchDir   = '0;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_reset();
        Reset            = 1'b1;
        bus.iStall       = 1'b0;
        bus.iBranchTaken = 1'b0;
        bus.iBranchDir   = '0;
        @(negedge Clock);
        @(negedge Clock);
        checks++;
        if (bus.oValid !== 1'b0 || bus.oInstr !== 16'h0000 || bus.oNewPC !== 10'd0 || bus.oInstrAddr !== 10'd0) begin
            errors++;
            $display("FAIL reset_values: valid=%b instr=%h newpc=%h addr=%h, want 0/0000/000/000",
                     bus.oValid, bus.oInstr, bus.oNewPC, bus.oInstrAddr);
        end
        Reset = 1'b0;
        cyc   = 0;
        checks++;
        if (bus.oInstrAddr !== 10'd0) begin
            errors++;
            $display("FAIL reset_c0_addr: got %h want 000", bus.oInstrAddr);
        end
        tick();
        checks++;
        if (bus.oInstrAddr !== 10'd1 || bus.oValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_c1: addr=%h valid=%b, want 001/0", bus.oInstrAddr, bus.oValid);
        end
    endtask

    task automatic test_stream();
        logic [15:0] ei;
        logic [9:0]  ep;
        start();
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) tick();
            if (c < 2) begin
                checks++;
                if (bus.oValid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_bubble c%0d: valid=%b want 0", c, bus.oValid);
                end
            end else begin
                ei = 16'hA000 + 16'(c - 2);
                ep = 10'(c - 1);
                checks++;
                if (bus.oValid !== 1'b1 || bus.oInstr !== ei || bus.oNewPC !== ep) begin
                    errors++;
                    $display("FAIL stream c%0d: valid=%b instr=%h newpc=%h, want 1/%h/%h",
                             c, bus.oValid, bus.oInstr, bus.oNewPC, ei, ep);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] ei;
        logic [9:0]  ep;
        start();
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) tick();
            bus.iStall = (c >= 4 && c <= 6);
            if (c >= 4) begin
                if (c <= 7)      begin ei = 16'hA002; ep = 10'h003; end
                else if (c == 8) begin ei = 16'hA003; ep = 10'h004; end
                else             begin ei = 16'hA004; ep = 10'h005; end
                checks++;
                if (bus.oValid !== 1'b1 || bus.oInstr !== ei || bus.oNewPC !== ep) begin
                    errors++;
                    $display("FAIL stall c%0d: valid=%b instr=%h newpc=%h, want 1/%h/%h",
                             c, bus.oValid, bus.oInstr, bus.oNewPC, ei, ep);
                end
            end
        end
        bus.iStall = 1'b0;
    endtask

    task automatic test_stall_fill();
        start();
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) tick();
            bus.iStall = (c <= 1);
            if (c >= 1 && c <= 2) begin
                checks++;
                if (bus.oInstrAddr !== 10'd0 || bus.oValid !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_stall c%0d: addr=%h valid=%b, want 000/0", c, bus.oInstrAddr, bus.oValid);
                end
            end
            if (c == 3) begin
                checks++;
                if (bus.oValid !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_stall c3: valid=%b want 0", bus.oValid);
                end
            end
            if (c == 4) begin
                checks++;
                if (bus.oValid !== 1'b1 || bus.oInstr !== 16'hA000 || bus.oNewPC !== 10'd1) begin
                    errors++;
                    $display("FAIL fill_stall c4: valid=%b instr=%h newpc=%h, want 1/a000/001",
                             bus.oValid, bus.oInstr, bus.oNewPC);
                end
            end
        end
    endtask

    task automatic test_branch();
        start();
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) tick();
            bus.iBranchTaken = (c == 5);
            bus.iBranchDir   = 10'h3F0;
            if (c == 6) begin
                checks++;
                if (bus.oValid !== 1'b0 || bus.oInstr !== 16'h0000 || bus.oNewPC !== 10'h004) begin
                    errors++;
                    $display("FAIL branch c6: valid=%b instr=%h newpc=%h, want 0/0000/004",
                             bus.oValid, bus.oInstr, bus.oNewPC);
                end
            end
            if (c == 7) begin
                checks++;
                if (bus.oValid !== 1'b0) begin
                    errors++;
                    $display("FAIL branch c7: valid=%b want 0", bus.oValid);
                end
            end
            if (c == 8) begin
                checks++;
                if (bus.oValid !== 1'b1 || bus.oInstr !== 16'hA3F0 || bus.oNewPC !== 10'h3F1) begin
                    errors++;
                    $display("FAIL branch c8: valid=%b instr=%h newpc=%h, want 1/a3f0/3f1",
                             bus.oValid, bus.oInstr, bus.oNewPC);
                end
            end
            if (c == 9) begin
                checks++;
                if (bus.oInstr !== 16'hA3F1 || bus.oNewPC !== 10'h3F2) begin
                    errors++;
                    $display("FAIL branch c9: instr=%h newpc=%h, want a3f1/3f2", bus.oInstr, bus.oNewPC);
                end
            end
        end
        bus.iBranchTaken = 1'b0;
    endtask

    task automatic test_wrap();
        logic [9:0]  a;
        logic [15:0] ei;
        start();
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) tick();
            bus.iBranchTaken = (c == 3);
            bus.iBranchDir   = 10'h3FE;
            if (c >= 6) begin
                a  = 10'h3FE + 10'(c - 6);
                ei = 16'hA000 + {6'd0, a};
                checks++;
                if (bus.oValid !== 1'b1 || bus.oInstr !== ei || bus.oNewPC !== 10'(a + 10'd1)) begin
                    errors++;
                    $display("FAIL wrap c%0d: valid=%b instr=%h newpc=%h, want 1/%h/%h",
                             c, bus.oValid, bus.oInstr, bus.oNewPC, ei, 10'(a + 10'd1));
                end
            end
        end
        bus.iBranchTaken = 1'b0;
    endtask

    task automatic test_branch_stall();
        start();
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) tick();
            bus.iBranchTaken = (c == 3);
            bus.iStall       = (c == 3);
            bus.iBranchDir   = 10'h100;
            if (c == 4 || c == 5) begin
                checks++;
                if (bus.oValid !== 1'b0) begin
                    errors++;
                    $display("FAIL br_stall c%0d: valid=%b want 0", c, bus.oValid);
                end
            end
            if (c == 6) begin
                checks++;
                if (bus.oValid !== 1'b1 || bus.oInstr !== 16'hA100 || bus.oNewPC !== 10'h101) begin
                    errors++;
                    $display("FAIL br_stall c6: valid=%b instr=%h newpc=%h, want 1/a100/101",
                             bus.oValid, bus.oInstr, bus.oNewPC);
                end
            end
        end
        bus.iBranchTaken = 1'b0;
        bus.iStall       = 1'b0;
    endtask

    task automatic test_branch_in_fill();
        start();
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) tick();
            bus.iBranchTaken = (c == 3 || c == 4);
            bus.iBranchDir   = (c == 3) ? 10'h200 : 10'h020;
            if (c == 5 || c == 6) begin
                checks++;
                if (bus.oValid !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_branch c%0d: valid=%b instr=%h, want 0", c, bus.oValid, bus.oInstr);
                end
            end
            if (c == 7) begin
                checks++;
                if (bus.oValid !== 1'b1 || bus.oInstr !== 16'hA020 || bus.oNewPC !== 10'h021) begin
                    errors++;
                    $display("FAIL fill_branch c7: valid=%b instr=%h newpc=%h, want 1/a020/021",
                             bus.oValid, bus.oInstr, bus.oNewPC);
                end
            end
            if (c == 8) begin
                checks++;
                if (bus.oInstr !== 16'hA021 || bus.oNewPC !== 10'h022) begin
                    errors++;
                    $display("FAIL fill_branch c8: instr=%h newpc=%h, want a021/022", bus.oInstr, bus.oNewPC);
                end
            end
        end
        bus.iBranchTaken = 1'b0;
    endtask

    task automatic test_reset_mid();
        start();
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) tick();
            Reset = (c == 5);
            if (c == 5) begin
                checks++;
                if (bus.oValid !== 1'b1 || bus.oInstr !== 16'hA003) begin
                    errors++;
                    $display("FAIL rst_mid pre c5: valid=%b instr=%h, want 1/a003", bus.oValid, bus.oInstr);
                end
            end
            if (c == 6) begin
                checks++;
                if (bus.oValid !== 1'b0 || bus.oInstr !== 16'h0000 || bus.oNewPC !== 10'd0 || bus.oInstrAddr !== 10'd0) begin
                    errors++;
                    $display("FAIL rst_mid c6: valid=%b instr=%h newpc=%h addr=%h, want 0/0000/000/000",
                             bus.oValid, bus.oInstr, bus.oNewPC, bus.oInstrAddr);
                end
            end
            if (c == 7) begin
                checks++;
                if (bus.oValid !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_mid c7: valid=%b want 0", bus.oValid);
                end
            end
            if (c == 8) begin
                checks++;
                if (bus.oValid !== 1'b1 || bus.oInstr !== 16'hA000 || bus.oNewPC !== 10'd1) begin
                    errors++;
                    $display("FAIL rst_mid c8: valid=%b instr=%h newpc=%h, want 1/a000/001",
                             bus.oValid, bus.oInstr, bus.oNewPC);
                end
            end
        end
        Reset = 1'b0;
    endtask

    initial begin
        bus.iStall       = 1'b0;
        bus.iBranchTaken = 1'b0;
        bus.iBranchDir   = '0;
        test_reset();
        test_stream();
        test_stall();
        test_stall_fill();
        test_branch();
        test_wrap();
        test_branch_stall();
        test_branch_in_fill();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 8-bit accumulator pipeline. It owns the 10-bit program counter, drives a synchronous-read instruction ROM, and hands each 16-bit instruction plus its PC+1 value to the ID stage. It redirects on the taken-branch signal resolved in EX (`branchTaken` / `branchDir_EX`). It holds on a pipeline stall and emits bubbles while the ROM pipeline refills.

## Interface
- `ADDR_W`, 10: program-counter and instruction-address width.
- `INSTR_W`, 16: instruction width; opcode in `[15:10]`, info in `[9:0]`.
- `NOP_INSTR`, 16'h0000: word driven on `oInstr` during bubbles.
- `Clock`  in  1  sole clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high.
- `iStall`  in  1  hold request from downstream; freezes PC and outputs.
- `iBranchTaken`  in  1  from EX `branchTaken`; one-cycle pulse, redirect request.
- `iBranchDir`  in  ADDR_W  from EX `branchDir_EX`; redirect target, sampled when `iBranchTaken`=1.
- `oInstrAddr`  out  ADDR_W  address to the instruction ROM. The ROM returns data on `iInstrData` one cycle later.
- `iInstrData`  in  INSTR_W  ROM read data.
- `oInstr`  out  INSTR_W  registered instruction to ID.
- `oNewPC`  out  ADDR_W  registered (address of `oInstr`)+1, base for ID relative branches.
- `oValid`  out  1  registered; 1 = `oInstr` is a real fetched instruction, 0 = bubble.

## Operation
- Internal registers:
  - `pc`: next address to issue.
  - `fetchAddr`: address whose data is on `iInstrData` this cycle.
  - `state`: FILL or RUN.
- Address mux (combinational): `oInstrAddr = (state==RUN && iStall) ? fetchAddr : pc`. Re-issuing `fetchAddr` under a stall keeps the ROM returning the word that matches `fetchAddr`.
- Priority per cycle, highest first: `Reset` > `iBranchTaken` > `iStall` > normal.
- Reset: `pc`=0, `fetchAddr`=0, `state`=FILL, `oInstr`=NOP_INSTR, `oNewPC`=0, `oValid`=0.
- Branch (any state):
  - `pc`<=`iBranchDir`, `state`<=FILL.
  - `oInstr`<=NOP_INSTR, `oValid`<=0.
  - `oNewPC` holds.
  - The ROM word in flight is discarded.
- FILL, no stall:
  - `fetchAddr`<=`pc`, `pc`<=`pc`+1, `state`<=RUN.
  - Outputs: `oInstr`<=NOP_INSTR, `oValid`<=0.
- FILL with `iStall`: everything holds, state remains FILL.
- RUN, no stall:
  - `oInstr`<=`iInstrData`, `oNewPC`<=`fetchAddr`+1, `oValid`<=1.
  - `fetchAddr`<=`pc`, `pc`<=`pc`+1.
- RUN with `iStall`: `pc`, `fetchAddr`, `oInstr`, `oNewPC` and `oValid` all hold.
- Arithmetic: all PC increments are modulo 2^ADDR_W; 1023+1 wraps to 0 with no flag. `iBranchDir` is used verbatim; it is already absolute, computed by ID/EX.
- Opcodes are never inspected; JMP/branch handling is entirely through `iBranchTaken`.

## Timing
- Reset released before cycle 0:
  - Cycle 0: FILL, address 0.
  - Cycle 1: RUN, address 1, data(0) arrives.
  - From cycle 2: `oInstr`=word0, `oNewPC`=1, `oValid`=1.
- Steady state: one instruction per cycle, consecutive addresses.
- Redirect penalty, with `iBranchTaken` sampled high at the edge ending cycle T:
  - Cycles T+1 and T+2: `oValid`=0.
  - Cycle T+3: `oInstr`=word(target), `oNewPC`=target+1.
- Instructions already delivered to ID before the pulse are ID/EX's responsibility to squash; this block guarantees only its own bubbles.
- Simultaneous `iBranchTaken` and `iStall`: the branch wins and the redirect proceeds.
- A branch during FILL restarts FILL with the new target.
- Stall during a bubble: bubble outputs hold (`oValid` stays 0).
- Stall of N cycles in RUN: outputs frozen N cycles. Next word appears the cycle after `iStall` falls, with no skipped or duplicated address.
- Reset mid-operation: next cycle matches the reset values exactly, regardless of state, stall or branch.
- `oInstrAddr` is the only combinational output and depends only on `state`, `iStall`, `pc`, `fetchAddr`.

## Test plan
- ROM word(k)=16'hA000+k; release reset, no stall -> `oValid`=0 in cycles 0-1; cycles 2..6 show `oInstr`=A000..A004 with `oNewPC`=1..5.
- Stall high cycles 4-6 (3 cycles) -> `oInstr`=A002/`oNewPC`=3 held through cycle 7. Cycle 8 shows A003/4 and cycle 9 shows A004/5, with no gap or repeat.
- `iBranchTaken`=1, `iBranchDir`=10'h3F0 in cycle 5 -> `oValid`=0 cycles 6-7; cycle 8 `oInstr`=A3F0, `oNewPC`=3F1; cycle 9 A3F1.
- Branch to 10'h3FE, then run -> sequence 3FE, 3FF, 000, 001 with `oNewPC`=3FF, 000, 001, 002 (wrap).
- `iBranchTaken` and `iStall` both high in the same cycle -> redirect taken, target word emitted 3 cycles later. Second branch to 10'h020 during FILL -> first target never emitted; word(020) appears 3 cycles after the second pulse.
- Assert `Reset` mid-stream for 1 cycle -> next cycle `oValid`=0, `oInstr`=0000, `oNewPC`=0, `oInstrAddr`=0; word0 emitted 2 cycles after release.
